pipelined_barrel_shifter: RTL and testbench

//   Parametrised, pipelined barrel shifter: logical/arithmetic shifts plus rotates, either direction.

---
 rtl/pipelined_barrel_shifter.sv | 177 +++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: logical/arithmetic shifts and rotates in either direction.
// The shift amount is split into SHW = log2(WIDTH) registered stages; stage s applies
// a shift of 2^s when bit s of the amount is set. Valid/ready flow control on both
// sides sustains one operation per cycle and lets bubbles collapse under backpressure.
// Optional feature macro: BSH_CARRY_EN adds the out_carry port and its pipeline bits.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_lr,
    input  logic             in_al,
    input  logic             in_rot,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef BSH_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    logic [WIDTH-1:0] w_srcData  [SHW];
    logic [SHW-1:0]   w_srcShamt [SHW];
    logic             w_srcLr    [SHW];
    logic             w_srcAl    [SHW];
    logic             w_srcRot   [SHW];
    logic [TAG_W-1:0] w_srcTag   [SHW];
    logic             w_srcValid [SHW];
    logic [WIDTH-1:0] w_nxtData  [SHW];
    logic [SHW-1:0]   w_load;

    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_shamt [SHW];
    logic             r_lr    [SHW];
    logic             r_al    [SHW];
    logic             r_rot   [SHW];
    logic [TAG_W-1:0] r_tag   [SHW];
    logic [SHW-1:0]   r_valid;

`ifdef BSH_CARRY_EN
    logic             w_srcCarry [SHW];
    logic             w_nxtCarry [SHW];
    logic             r_carry    [SHW];
`endif

    // Stage 0 takes the operation from the input port, later stages from the stage before
    for (genvar gs = 0; gs < SHW; gs++) begin : g_src
        if (gs == 0) begin : g_first
            assign w_srcData[gs]  = in_data;
            assign w_srcShamt[gs] = in_shamt;
            assign w_srcLr[gs]    = in_lr;
            assign w_srcAl[gs]    = in_al;
            assign w_srcRot[gs]   = in_rot;
            assign w_srcTag[gs]   = in_tag;
            assign w_srcValid[gs] = in_valid;
`ifdef BSH_CARRY_EN
            assign w_srcCarry[gs] = 1'b0;
`endif
        end else begin : g_next
            assign w_srcData[gs]  = r_data[gs-1];
            assign w_srcShamt[gs] = r_shamt[gs-1];
            assign w_srcLr[gs]    = r_lr[gs-1];
            assign w_srcAl[gs]    = r_al[gs-1];
            assign w_srcRot[gs]   = r_rot[gs-1];
            assign w_srcTag[gs]   = r_tag[gs-1];
            assign w_srcValid[gs] = r_valid[gs-1];
`ifdef BSH_CARRY_EN
            assign w_srcCarry[gs] = r_carry[gs-1];
`endif
        end
    end

    // Each stage shifts or rotates its operand by 2^s when bit s of the amount is set;
    // an arithmetic right shift refills from the current MSB, which still holds the
    // sign captured at accept because earlier stages preserved it
    always_comb begin
        for (int s = 0; s < SHW; s++) begin
            w_nxtData[s] = w_srcData[s];
`ifdef BSH_CARRY_EN
            w_nxtCarry[s] = w_srcCarry[s];
`endif
            if (w_srcShamt[s][s]) begin
                if (w_srcRot[s]) begin
                    if (w_srcLr[s]) begin
                        w_nxtData[s] = (w_srcData[s] >> (1 << s)) | (w_srcData[s] << (WIDTH - (1 << s)));
`ifdef BSH_CARRY_EN
                        w_nxtCarry[s] = w_nxtData[s][WIDTH-1];
`endif
                    end else begin
                        w_nxtData[s] = (w_srcData[s] << (1 << s)) | (w_srcData[s] >> (WIDTH - (1 << s)));
`ifdef BSH_CARRY_EN
                        w_nxtCarry[s] = w_nxtData[s][0];
`endif
                    end
                end else if (w_srcLr[s]) begin
                    if (w_srcAl[s]) begin
                        w_nxtData[s] = $signed(w_srcData[s]) >>> (1 << s);
                    end else begin
                        w_nxtData[s] = w_srcData[s] >> (1 << s);
                    end
`ifdef BSH_CARRY_EN
                    w_nxtCarry[s] = w_srcData[s][(1 << s) - 1];
`endif
                end else begin
                    w_nxtData[s] = w_srcData[s] << (1 << s);
`ifdef BSH_CARRY_EN
                    w_nxtCarry[s] = w_srcData[s][WIDTH - (1 << s)];
`endif
                end
            end
        end
    end

    // A stage may load when the output drains this cycle or some stage from it to the end is empty
    always_comb begin
        logic w_allFull;
        w_allFull = 1'b1;
        w_load    = '0;
        for (int s = SHW - 1; s >= 0; s--) begin
            w_allFull = w_allFull & r_valid[s];
            w_load[s] = out_ready | ~w_allFull;
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_data[SHW-1];
    assign out_tag   = r_tag[SHW-1];
`ifdef BSH_CARRY_EN
    assign out_carry = r_carry[SHW-1];
`endif

    // Move operations down the pipe; a stage that cannot load holds its contents unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < SHW; s++) begin
                r_data[s]  <= '0;
                r_shamt[s] <= '0;
                r_lr[s]    <= 1'b0;
                r_al[s]    <= 1'b0;
                r_rot[s]   <= 1'b0;
                r_tag[s]   <= '0;
`ifdef BSH_CARRY_EN
                r_carry[s] <= 1'b0;
`endif
            end
        end else begin
            for (int s = 0; s < SHW; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= w_srcValid[s];
                    if (w_srcValid[s]) begin
                        r_data[s]  <= w_nxtData[s];
                        r_shamt[s] <= w_srcShamt[s];
                        r_lr[s]    <= w_srcLr[s];
                        r_al[s]    <= w_srcAl[s];
                        r_rot[s]   <= w_srcRot[s];
                        r_tag[s]   <= w_srcTag[s];
`ifdef BSH_CARRY_EN
                        r_carry[s] <= w_nxtCarry[s];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at WIDTH=8, TAG_W=4.
// Expected results come from a whole-word reference model pushed to a scoreboard queue
// on accept and popped on retire. Carry checks are compiled in with BSH_CARRY_EN.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int SHW   = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             carry;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_lr;
    logic             in_al;
    logic             in_rot;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef BSH_CARRY_EN
    logic             out_carry;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t scoreQ[$];

    logic [WIDTH-1:0] curData;
    logic [SHW-1:0]   curShamt;
    logic             curLr, curAl, curRot;
    logic [TAG_W-1:0] curTag;
    logic [TAG_W-1:0] tagCnt = '0;

    logic [WIDTH-1:0] sData;
    logic [TAG_W-1:0] sTag;
    logic             sCarry;
    logic             sValid, sReady;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
        .in_lr(in_lr), .in_al(in_al), .in_rot(in_rot), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef BSH_CARRY_EN
        , .out_carry(out_carry)
`endif
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Whole-word reference: shifts of the full operand, rotates via a doubled word
    function automatic exp_t refModel(input logic [WIDTH-1:0] d, input logic [SHW-1:0] n,
                                      input logic lr, input logic al, input logic rot,
                                      input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [2*WIDTH-1:0] dbl;
        logic [2*WIDTH-1:0] tmp;
        dbl     = {d, d};
        e.tag   = tag;
        e.carry = 1'b0;
        if (rot) begin
            if (lr) begin
                tmp    = dbl >> n;
                e.data = tmp[WIDTH-1:0];
            end else begin
                tmp    = dbl << n;
                e.data = tmp[2*WIDTH-1:WIDTH];
            end
            if (n != 0) e.carry = lr ? e.data[WIDTH-1] : e.data[0];
        end else if (!lr) begin
            e.data = d << n;
            if (n != 0) e.carry = d[WIDTH - int'(n)];
        end else begin
            if (al) e.data = $signed(d) >>> n;
            else    e.data = d >> n;
            if (n != 0) e.carry = d[int'(n) - 1];
        end
        return e;
    endfunction

    // Random operation with an incrementing tag so ordering is visible
    task automatic newOp();
        curData  = WIDTH'($urandom);
        curShamt = SHW'($urandom_range(0, WIDTH - 1));
        curLr    = 1'($urandom_range(0, 1));
        curAl    = 1'($urandom_range(0, 1));
        curRot   = 1'($urandom_range(0, 1));
        curTag   = tagCnt;
        tagCnt   = tagCnt + 1'b1;
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later, record accept in the scoreboard
    task automatic applyStimulus(input logic v, input logic ordy, output logic acc, output logic ret);
        @(negedge clk);
        in_valid  = v;
        in_data   = curData;
        in_shamt  = curShamt;
        in_lr     = curLr;
        in_al     = curAl;
        in_rot    = curRot;
        in_tag    = curTag;
        out_ready = ordy;
        #1;
        acc    = in_valid & in_ready;
        ret    = out_valid & out_ready;
        sValid = out_valid;
        sReady = in_ready;
        sData  = out_data;
        sTag   = out_tag;
`ifdef BSH_CARRY_EN
        sCarry = out_carry;
`else
        sCarry = 1'b0;
`endif
        if (acc) scoreQ.push_back(refModel(curData, curShamt, curLr, curAl, curRot, curTag));
    endtask

    // Outputs cleared while reset is held, ready to accept right after release
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_tag} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h tag=%h, want all 0", out_valid, out_data, out_tag);
        end
`ifdef BSH_CARRY_EN
        checks++;
        if (out_carry !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_carry: got %b want 0", out_carry);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // Known vectors one at a time, including exact accept-to-valid latency
    task automatic test_directed();
        logic [WIDTH-1:0] dIn  [6] = '{8'hB5, 8'h96, 8'h96, 8'h96, 8'h81, 8'h81};
        logic [SHW-1:0]   nIn  [6] = '{3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd7};
        logic             lrIn [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic             alIn [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic             rtIn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] dExp [6] = '{8'hA8, 8'hE5, 8'h25, 8'h96, 8'h03, 8'h03};
        logic             cExp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic acc, ret, got;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            curData = dIn[i]; curShamt = nIn[i]; curLr = lrIn[i]; curAl = alIn[i]; curRot = rtIn[i];
            curTag  = TAG_W'(i + 1);
            applyStimulus(1'b1, 1'b1, acc, ret);
            checks++;
            if (acc !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dir%0d_accept: got %b want 1", i, acc);
            end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 10) begin
                applyStimulus(1'b0, 1'b1, acc, ret);
                lat++;
                if (ret) got = 1'b1;
            end
            checks++;
            if (!got || lat != SHW) begin
                failures++;
                $display("[TB] FAIL dir%0d_latency: got %0d cycles (seen=%b) want %0d", i, lat, got, SHW);
            end
            if (got) begin
                checks++;
                if ({sData, sTag} !== {dExp[i], TAG_W'(i + 1)}) begin
                    failures++;
                    $display("[TB] FAIL dir%0d_data: got %h/tag %0d want %h/tag %0d", i, sData, sTag, dExp[i], i + 1);
                end
`ifdef BSH_CARRY_EN
                checks++;
                if (sCarry !== cExp[i]) begin
                    failures++;
                    $display("[TB] FAIL dir%0d_carry: got %b want %b", i, sCarry, cExp[i]);
                end
`endif
                if (scoreQ.size() > 0) void'(scoreQ.pop_front());
            end
        end
        scoreQ.delete();
    endtask

    // 16 ops streamed with out_ready high: in_ready never drops, one retire per cycle
    task automatic test_back_to_back();
        logic acc, ret;
        exp_t e;
        int sent = 0, retired = 0, cyc = 0, firstRet = -1, lastRet = -1, budget = 20;
        newOp();
        while (sent < 16) begin
            applyStimulus(1'b1, 1'b1, acc, ret);
            checks++;
            if (sReady !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_in_ready: cycle %0d got %b want 1", cyc, sReady);
            end
            if (acc) begin sent++; newOp(); end
            if (ret) begin
                retired++;
                if (firstRet < 0) firstRet = cyc;
                lastRet = cyc;
                checks++;
                if (scoreQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL b2b_spurious: got data %h tag %0d, want no retire", sData, sTag);
                end else begin
                    e = scoreQ.pop_front();
                    if ({sData, sTag} !== {e.data, e.tag}) begin
                        failures++;
                        $display("[TB] FAIL b2b_result: got %h/tag %0d want %h/tag %0d", sData, sTag, e.data, e.tag);
                    end
`ifdef BSH_CARRY_EN
                    checks++;
                    if (sCarry !== e.carry) begin
                        failures++;
                        $display("[TB] FAIL b2b_carry: got %b want %b", sCarry, e.carry);
                    end
`endif
                end
            end
            cyc++;
        end
        while (scoreQ.size() > 0 && budget > 0) begin
            applyStimulus(1'b0, 1'b1, acc, ret);
            budget--;
            if (ret) begin
                retired++;
                if (firstRet < 0) firstRet = cyc;
                lastRet = cyc;
                e = scoreQ.pop_front();
                checks++;
                if ({sData, sTag} !== {e.data, e.tag}) begin
                    failures++;
                    $display("[TB] FAIL b2b_result: got %h/tag %0d want %h/tag %0d", sData, sTag, e.data, e.tag);
                end
`ifdef BSH_CARRY_EN
                checks++;
                if (sCarry !== e.carry) begin
                    failures++;
                    $display("[TB] FAIL b2b_carry: got %b want %b", sCarry, e.carry);
                end
`endif
            end
            cyc++;
        end
        checks++;
        if (retired != 16 || lastRet - firstRet != 15) begin
            failures++;
            $display("[TB] FAIL b2b_throughput: got %0d retires over span %0d, want 16 over span 15", retired, lastRet - firstRet);
        end
        scoreQ.delete();
    endtask

    // Output stalled 6 cycles while streaming: 3 accepts fill the pipe, head held, nothing lost
    task automatic test_stall();
        logic acc, ret;
        exp_t e;
        int accCount = 0, total, retired = 0, budget = 40;
        newOp();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, acc, ret);
            if (acc) begin accCount++; newOp(); end
            if (i >= SHW) begin
                checks++;
                if (sReady !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_in_ready: cycle %0d got %b want 0", i, sReady);
                end
                checks++;
                if (scoreQ.size() == 0 || sValid !== 1'b1 || {sData, sTag} !== {scoreQ[0].data, scoreQ[0].tag}) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: cycle %0d got valid=%b %h/tag %0d, want head of queue held",
                             i, sValid, sData, sTag);
                end
            end
        end
        checks++;
        if (accCount != SHW) begin
            failures++;
            $display("[TB] FAIL stall_accepts: got %0d want %0d", accCount, SHW);
        end
        total = accCount;
        while ((total < 10 || scoreQ.size() > 0) && budget > 0) begin
            applyStimulus(total < 10, 1'b1, acc, ret);
            budget--;
            if (acc) begin total++; newOp(); end
            if (ret) begin
                retired++;
                checks++;
                if (scoreQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL stall_spurious: got data %h tag %0d, want no retire", sData, sTag);
                end else begin
                    e = scoreQ.pop_front();
                    if ({sData, sTag} !== {e.data, e.tag}) begin
                        failures++;
                        $display("[TB] FAIL stall_result: got %h/tag %0d want %h/tag %0d", sData, sTag, e.data, e.tag);
                    end
`ifdef BSH_CARRY_EN
                    checks++;
                    if (sCarry !== e.carry) begin
                        failures++;
                        $display("[TB] FAIL stall_carry: got %b want %b", sCarry, e.carry);
                    end
`endif
                end
            end
        end
        checks++;
        if (retired != total || total != 10) begin
            failures++;
            $display("[TB] FAIL stall_count: got %0d retired of %0d accepted, want 10 of 10", retired, total);
        end
        scoreQ.delete();
    endtask

    // Reset asserted mid-cycle with two ops in flight: outputs clear at once, nothing retires
    task automatic test_reset_inflight();
        logic acc, ret;
        int   strayRet = 0;
        newOp();
        applyStimulus(1'b1, 1'b0, acc, ret);
        newOp();
        applyStimulus(1'b1, 1'b0, acc, ret);
        applyStimulus(1'b0, 1'b0, acc, ret);
        applyStimulus(1'b0, 1'b0, acc, ret);
        checks++;
        if (sValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_pre_valid: got %b want 1", sValid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_tag} !== '0) begin
            failures++;
            $display("[TB] FAIL rst_async: got valid=%b data=%h tag=%h, want all 0", out_valid, out_data, out_tag);
        end
        scoreQ.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, acc, ret);
            if (sValid) strayRet++;
        end
        checks++;
        if (strayRet != 0 || sReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_flush: got %0d stray outputs, in_ready=%b, want 0 and 1", strayRet, sReady);
        end
    endtask

    // 10k random ops with random in_valid and out_ready against the reference model
    task automatic test_random();
        logic acc, ret, pending = 1'b0;
        exp_t e;
        int sent = 0, cyc = 0, budget = 50;
        while (sent < 10000 && cyc < 60000) begin
            if (!pending && $urandom_range(0, 3) != 0) begin newOp(); pending = 1'b1; end
            applyStimulus(pending, $urandom_range(0, 3) != 0, acc, ret);
            if (acc) begin sent++; pending = 1'b0; end
            if (ret) begin
                checks++;
                if (scoreQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rnd_spurious: got data %h tag %0d, want no retire", sData, sTag);
                end else begin
                    e = scoreQ.pop_front();
                    if ({sData, sTag} !== {e.data, e.tag}) begin
                        failures++;
                        $display("[TB] FAIL rnd_result: got %h/tag %0d want %h/tag %0d", sData, sTag, e.data, e.tag);
                    end
`ifdef BSH_CARRY_EN
                    checks++;
                    if (sCarry !== e.carry) begin
                        failures++;
                        $display("[TB] FAIL rnd_carry: got %b want %b (data %h)", sCarry, e.carry, e.data);
                    end
`endif
                end
            end
            cyc++;
        end
        while (scoreQ.size() > 0 && budget > 0) begin
            applyStimulus(1'b0, 1'b1, acc, ret);
            budget--;
            if (ret) begin
                e = scoreQ.pop_front();
                checks++;
                if ({sData, sTag} !== {e.data, e.tag}) begin
                    failures++;
                    $display("[TB] FAIL rnd_result: got %h/tag %0d want %h/tag %0d", sData, sTag, e.data, e.tag);
                end
            end
        end
        checks++;
        if (sent != 10000 || scoreQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL rnd_complete: got %0d sent, %0d pending, want 10000 sent, 0 pending", sent, scoreQ.size());
        end
    endtask

    // Run every scenario in order and report
    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        curData = '0; curShamt = '0; curLr = 1'b0; curAl = 1'b0; curRot = 1'b0; curTag = '0;
        in_data = '0; in_shamt = '0; in_lr = 1'b0; in_al = 1'b0; in_rot = 1'b0; in_tag = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
